// File: rtl/seq_detect_param.sv
// Serial pattern detector with a loadable PAT_W-bit pattern, selectable
// overlapping / non-overlapping detection and a registered match pulse.
// Optional feature macro: SEQ_DETECT_COUNT_EN adds a saturating match
// counter with synchronous clear; without it match_count is tied to zero.
module seq_detect_param #(
    parameter int              PAT_W    = 4,
    parameter logic [PAT_W-1:0] PAT_INIT = 4'b1101,
    parameter int              CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             din,
    input  logic             load,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    input  logic             clr_cnt,
    output logic             detected,
    output logic [CNT_W-1:0] match_count
);

    localparam int FW = (PAT_W > 2) ? $clog2(PAT_W) : 1;

    typedef enum logic [0:0] {FILL, ARMED} state_t;

    state_t           r_state,   w_stateNext;
    logic [PAT_W-2:0] r_hist,    w_histNext;
    logic [FW-1:0]    r_fill,    w_fillNext;
    logic [PAT_W-1:0] r_pat,     w_patNext;
    logic             r_det,     w_detNext;
    logic [PAT_W-1:0] w_window;
    logic             w_match;

    // Window of the most recent PAT_W bits including the bit arriving now.
    assign w_window = {r_hist, din};
    assign w_match  = (r_state == ARMED) && en && !load && (w_window == r_pat);

    // Next-state logic: load has priority, then consuming a valid bit.
    always_comb begin
        w_stateNext = r_state;
        w_histNext  = r_hist;
        w_fillNext  = r_fill;
        w_patNext   = r_pat;
        w_detNext   = 1'b0;
        if (load) begin
            w_patNext   = pattern;
            w_histNext  = '0;
            w_fillNext  = '0;
            w_stateNext = FILL;
        end else if (en) begin
            w_histNext = w_window[PAT_W-2:0];
            if (r_state == FILL) begin
                w_fillNext = r_fill + 1'b1;
                if (r_fill == FW'(PAT_W-2)) begin
                    w_stateNext = ARMED;
                end
            end
            if (w_match) begin
                w_detNext = 1'b1;
                if (!overlap) begin
                    w_histNext  = '0;
                    w_fillNext  = '0;
                    w_stateNext = FILL;
                end
            end
        end
    end

    // State, history, pattern and pulse registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= FILL;
            r_hist  <= '0;
            r_fill  <= '0;
            r_pat   <= PAT_INIT;
            r_det   <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_hist  <= w_histNext;
            r_fill  <= w_fillNext;
            r_pat   <= w_patNext;
            r_det   <= w_detNext;
        end
    end

    assign detected = r_det;

`ifdef SEQ_DETECT_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_count;

    // Saturating match counter; clear wins over a simultaneous match.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clr_cnt) begin
            r_count <= '0;
        end else if (w_match && (r_count != CNT_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign match_count = r_count;
`else
    logic w_unused;
    assign w_unused    = clr_cnt;
    assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed testbench for seq_detect_param.
// Two instances share stimulus: dutA (CNT_W=8) and dutB (CNT_W=2) for
// counter saturation. Expected counts honour SEQ_DETECT_COUNT_EN.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       din = 1'b0;
    logic       load = 1'b0;
    logic [3:0] pattern = 4'b0000;
    logic       overlap = 1'b1;
    logic       clrCnt = 1'b0;
    logic       detA, detB;
    logic [7:0] cntA;
    logic [1:0] cntB;

    int vectors = 0;
    int miscompares = 0;

    seq_detect_param #(.PAT_W(4), .PAT_INIT(4'b1101), .CNT_W(8)) dutA (
        .clk(clk), .reset(reset), .en(en), .din(din), .load(load),
        .pattern(pattern), .overlap(overlap), .clr_cnt(clrCnt),
        .detected(detA), .match_count(cntA)
    );

    seq_detect_param #(.PAT_W(4), .PAT_INIT(4'b1101), .CNT_W(2)) dutB (
        .clk(clk), .reset(reset), .en(en), .din(din), .load(load),
        .pattern(pattern), .overlap(overlap), .clr_cnt(clrCnt),
        .detected(detB), .match_count(cntB)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    // Expected counter value depending on whether the counter is built.
    function automatic logic [15:0] expCnt(input int n);
`ifdef SEQ_DETECT_COUNT_EN
        return 16'(n);
`else
        return 16'(n * 0);
`endif
    endfunction

    // Compare one observed value against its expectation and tally it.
    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then settle just after the rising edge.
    task automatic applyStimulus(input logic e, input logic d, input logic l, input logic c);
        en     = e;
        din    = d;
        load   = l;
        clrCnt = c;
        @(posedge clk);
        #1;
    endtask

    // Two reset cycles with din toggling, then release.
    task automatic doReset(input bit check);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, i[0], 1'b0, 1'b0);
            if (check) begin
                checkOutput("reset_det", {15'd0, detA}, 16'd0);
                checkOutput("reset_cnt", {8'd0, cntA}, 16'd0);
            end
        end
        reset = 1'b1;
    endtask

    logic [6:0] stream;
    logic [6:0] expOvl;
    logic [6:0] expNov;

    initial begin
        stream = 7'b1101101;
        expOvl = 7'b0001001;
        expNov = 7'b0001000;

        // Reset and first three valid bits never pulse
        doReset(1'b1);
        overlap = 1'b1;
        for (int i = 6; i >= 4; i--) begin
            applyStimulus(1'b1, stream[i], 1'b0, 1'b0);
            checkOutput("post_reset_det", {15'd0, detA}, 16'd0);
        end

        // Overlapping detection
        doReset(1'b0);
        overlap = 1'b1;
        for (int i = 6; i >= 0; i--) begin
            applyStimulus(1'b1, stream[i], 1'b0, 1'b0);
            checkOutput("ovl_det", {15'd0, detA}, {15'd0, expOvl[i]});
        end
        checkOutput("ovl_cnt", {8'd0, cntA}, expCnt(2));

        // Non-overlapping detection
        doReset(1'b0);
        overlap = 1'b0;
        for (int i = 6; i >= 0; i--) begin
            applyStimulus(1'b1, stream[i], 1'b0, 1'b0);
            checkOutput("nov_det", {15'd0, detA}, {15'd0, expNov[i]});
        end
        checkOutput("nov_cnt", {8'd0, cntA}, expCnt(1));

        // Gapped input: two idle cycles with inverted din between bits
        doReset(1'b0);
        overlap = 1'b1;
        for (int i = 6; i >= 3; i--) begin
            applyStimulus(1'b1, stream[i], 1'b0, 1'b0);
            checkOutput("gap_det", {15'd0, detA}, (i == 3) ? 16'd1 : 16'd0);
            if (i != 3) begin
                for (int g = 0; g < 2; g++) begin
                    applyStimulus(1'b0, ~stream[i], 1'b0, 1'b0);
                    checkOutput("gap_idle_det", {15'd0, detA}, 16'd0);
                end
            end
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("gap_hold_cnt", {8'd0, cntA}, expCnt(1));

        // Pattern load mid-stream, din discarded on the load edge
        doReset(1'b0);
        overlap = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        pattern = 4'b1111;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("load_det", {15'd0, detA}, 16'd0);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
            checkOutput("load_ones_det", {15'd0, detA}, (i >= 4) ? 16'd1 : 16'd0);
        end
        checkOutput("load_cnt", {8'd0, cntA}, expCnt(2));

        // Clear together with a match: pulse still appears, count zeroed
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("clr_match_det", {15'd0, detA}, 16'd1);
        checkOutput("clr_match_cnt", {8'd0, cntA}, 16'd0);

        // Saturation on the 2-bit counter: six overlapping matches of 1101
        doReset(1'b0);
        overlap = 1'b1;
        for (int i = 6; i >= 4; i--) begin
            applyStimulus(1'b1, stream[i], 1'b0, 1'b0);
        end
        for (int m = 1; m <= 6; m++) begin
            if (m > 1) begin
                applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
                applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            end
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
            checkOutput("sat_det", {15'd0, detB}, 16'd1);
            checkOutput("sat_cnt", {14'd0, cntB}, expCnt((m > 3) ? 3 : m));
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("sat_clr_cnt", {14'd0, cntB}, 16'd0);
        checkOutput("sat_clr_det", {15'd0, detB}, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter PAT_W, default 4, range 2..16: pattern length in bits.
REQ-002 Parameter PAT_INIT, default 4'b1101 (PAT_W bits): pattern in force after reset.
REQ-003 Parameter CNT_W, default 8, range 2..16: match counter width.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port reset, input, 1: synchronous, active-low reset.
REQ-006 Port en, input, 1: din valid; a bit is consumed only on an edge where en=1.
REQ-007 Port din, input, 1: serial data bit.
REQ-008 Port load, input, 1: one-cycle strobe to capture a new pattern.
REQ-009 Port pattern, input, PAT_W: new pattern, sampled when load=1; bit PAT_W-1 is the oldest (first-received) bit.
REQ-010 Port overlap, input, 1: 1 = overlapping detection, 0 = non-overlapping; sampled every cycle.
REQ-011 Port clr_cnt, input, 1: synchronous clear of match_count.
REQ-012 Port detected, output, 1: registered one-cycle match pulse.
REQ-013 Port match_count, output, CNT_W: registered saturating count of matches.

Function
REQ-014 Keep a PAT_W-1 bit history shift register, a pattern register pat_q, and a fill counter 0..PAT_W-1.
- Two states:
  - FILL: fill < PAT_W-1.
  - ARMED: fill = PAT_W-1.
REQ-015 On an edge with en=1 and load=0:
- Shift din into the history LSB.
- In FILL, increment fill; reaching PAT_W-1 moves the block to ARMED.
REQ-016 Match condition: state ARMED, en=1, load=0 and {history, din} == pat_q.
REQ-017 On the edge where the match condition is true, detected SHALL be 1 for exactly the following cycle (latency 1); otherwise detected SHALL be 0.
REQ-018 On a match with overlap=1, state stays ARMED and history keeps shifting, so suffix reuse is allowed.
REQ-019 On a match with overlap=0, fill and history clear to 0 and state returns to FILL; the matching bit is not reused.
REQ-020 On an edge with en=0, history, fill, state and match_count SHALL hold, and detected SHALL be 0.
REQ-021 load=1 takes priority over en:
- pat_q <= pattern.
- History and fill clear; state goes to FILL.
- din is discarded and detected = 0 next cycle.
REQ-022 match_count increments by 1 per match and saturates at 2^CNT_W-1; no wrap-around.
REQ-023 clr_cnt=1 clears match_count to 0.
- clr_cnt together with a match: count becomes 0; detected still pulses.
REQ-024 All outputs are driven only from registers; no combinational path from inputs to outputs.

Reset
REQ-025 While reset=0 at a rising edge, the following SHALL be set, overriding all other inputs:
- detected = 0, match_count = 0.
- history = 0, fill = 0, state = FILL.
- pat_q = PAT_INIT.
REQ-026 Asserting reset mid-sequence discards partial history; detection restarts from an empty FILL on the first edge with reset=1.

Configuration
REQ-027 Macro SEQ_DETECT_COUNT_EN:
- Defined: the match_count counter and clr_cnt behaviour are implemented as specified.
- Undefined: no counter logic; match_count is tied to 0, clr_cnt is ignored, and all other behaviour is unchanged.

Verification
REQ-028 The bench SHALL run with PAT_W=4, PAT_INIT=1101, CNT_W=8 unless stated otherwise, and SHALL cover these scenarios:
- Reset: reset=0 for 2 cycles with din toggling -> detected=0, match_count=0 throughout; no pulse within the first 3 valid bits after release.
- Overlap: overlap=1, en=1, stream 1,1,0,1,1,0,1 -> detected pulses in the cycles after bit 4 and bit 7; match_count=2.
- Non-overlap: overlap=0, same stream -> single pulse after bit 4; match_count=1.
- Gapped input: bits 1,1,0,1 with en=0 for 2 cycles between each bit -> one pulse after the final valid bit; no pulse during the gaps.
- Pattern load: load=1 with pattern=1111 mid-stream (en=1, din=1 on the same edge), then overlap=1 and five 1s -> pulses after the 4th and 5th bits only.
- Counter saturation and clear: CNT_W=2, overlap=1, six matches -> match_count=3; then clr_cnt=1 -> 0. With SEQ_DETECT_COUNT_EN undefined, match_count=0 always.
